// File: rtl/axi4_mem_responder_if.sv
// AXI4 bus bundle between the accelerator's m_axi master and the memory responder.
// There are no size or burst signals: every transfer is INCR with full-width beats.
interface axi4_mem_responder_if #(
  parameter int AXI_ADDR_W = 40,
  parameter int AXI_DATA_W = 256,
  parameter int AXI_ID_W   = 4
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave backed by a word-addressed SRAM; serves one write or read burst at a time
// and answers with an ID-tagged B or R response.
module axi4_mem_responder #(
  parameter int AXI_ADDR_W = 40,
  parameter int AXI_DATA_W = 256,
  parameter int AXI_ID_W   = 4,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi4_mem_responder_if.slave  s_axi
);
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int SPAN_W = IDX_W + 9;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_WAIT,
    RD_DATA
  } state_t;

  state_t              state_q, state_d;
  logic [AXI_ID_W-1:0] id_q, id_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                werr_q, werr_d;
  logic [15:0]         wait_q, wait_d;

  logic                aw_hs, ar_hs, w_hs;
  logic                last_beat;
  logic                mem_we, mem_re;
  logic [AXI_DATA_W-1:0] rd_word;

  // Flags addresses outside the memory or bursts that would run past its last word.
  function automatic logic addr_err(input logic [AXI_ADDR_W-1:0] addr, input logic [7:0] len);
    logic [SPAN_W-1:0] last_idx;
    last_idx = SPAN_W'(addr[OFF_W +: IDX_W]) + SPAN_W'(len);
    return ((addr >> (OFF_W + IDX_W)) != '0) || (last_idx > SPAN_W'(MEM_DEPTH - 1));
  endfunction

  assign s_axi.awready = rst_n && (state_q == IDLE);
  assign s_axi.arready = rst_n && (state_q == IDLE) && !s_axi.awvalid;
  assign s_axi.wready  = rst_n && (state_q == WR_DATA);
  assign s_axi.bvalid  = rst_n && (state_q == WR_RESP);
  assign s_axi.rvalid  = rst_n && (state_q == RD_DATA);

  assign aw_hs     = s_axi.awvalid && s_axi.awready;
  assign ar_hs     = s_axi.arvalid && s_axi.arready;
  assign w_hs      = s_axi.wvalid && s_axi.wready;
  assign last_beat = (cnt_q == len_q);

  assign s_axi.bid   = (state_q == WR_RESP) ? id_q : '0;
  assign s_axi.bresp = ((state_q == WR_RESP) && (err_q || werr_q)) ? 2'b10 : 2'b00;
  assign s_axi.rid   = (state_q == RD_DATA) ? id_q : '0;
  assign s_axi.rresp = ((state_q == RD_DATA) && err_q) ? 2'b10 : 2'b00;
  assign s_axi.rdata = ((state_q == RD_DATA) && !err_q) ? rd_word : '0;
  assign s_axi.rlast = (state_q == RD_DATA) && last_beat;

  assign mem_we = rst_n && w_hs && !err_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    werr_d  = werr_q;
    wait_d  = wait_q;
    mem_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = s_axi.awid;
          idx_d   = s_axi.awaddr[OFF_W +: IDX_W];
          len_d   = s_axi.awlen;
          cnt_d   = 8'd0;
          err_d   = addr_err(s_axi.awaddr, s_axi.awlen);
          werr_d  = 1'b0;
          state_d = WR_DATA;
        end else if (ar_hs) begin
          id_d   = s_axi.arid;
          idx_d  = s_axi.araddr[OFF_W +: IDX_W];
          len_d  = s_axi.arlen;
          cnt_d  = 8'd0;
          err_d  = addr_err(s_axi.araddr, s_axi.arlen);
          werr_d = 1'b0;
          if (RD_LATENCY == 0) begin
            state_d = RD_DATA;
            mem_re  = 1'b1;
          end else begin
            state_d = RD_WAIT;
            wait_d  = 16'(RD_LATENCY - 1);
          end
        end
      end
      WR_DATA: begin
        if (w_hs) begin
          idx_d = idx_q + IDX_W'(1);
          cnt_d = cnt_q + 8'd1;
          // The beat count alone ends the burst; a misplaced wlast only taints the response.
          if (s_axi.wlast != last_beat) begin
            werr_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (s_axi.bready) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (wait_q == 16'd0) begin
          state_d = RD_DATA;
          mem_re  = 1'b1;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      RD_DATA: begin
        if (s_axi.rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            // Prefetch the next word so beats stream back to back.
            idx_d  = idx_q + IDX_W'(1);
            cnt_d  = cnt_q + 8'd1;
            mem_re = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      werr_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      werr_q  <= werr_d;
      wait_q  <= wait_d;
    end
  end

  // One byte-wide RAM per strobe lane with a registered read port.
  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [MEM_DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (mem_we && s_axi.wstrb[gi]) begin
          lane_mem[idx_q] <= s_axi.wdata[gi*8 +: 8];
        end
        if (mem_re) begin
          lane_rd_q <= lane_mem[idx_d];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: bursts, strobes, backpressure, arbitration,
// error responses and reset in the middle of a read.
module tb_axi4_mem_responder;
  localparam int AW    = 40;
  localparam int DW    = 256;
  localparam int IW    = 4;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_mem_responder_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)) bus ();

  axi4_mem_responder #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_axi(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0]   model [int];
  logic [DW-1:0]   wbeat [16];
  logic [DW/8-1:0] wstrb_arr [16];
  logic [DW-1:0]   rd_got [16];
  bit              ar_pending = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len);
    bit hs;
    int t = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
    forever begin
      #1;
      hs = bus.awready;
      if (ar_pending) check({tag, " arready low vs aw"}, DW'(bus.arready), DW'(1'b0));
      tick();
      if (hs) break;
      if (++t > 50) begin check({tag, " aw timeout"}, DW'(bus.awready), DW'(1'b1)); break; end
    end
    bus.awvalid = 1'b0;
  endtask

  task automatic do_ar(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                       input logic [7:0] len);
    bit hs;
    int t = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
    forever begin
      #1;
      hs = bus.arready;
      tick();
      if (hs) break;
      if (++t > 50) begin check({tag, " ar timeout"}, DW'(bus.arready), DW'(1'b1)); break; end
    end
    bus.arvalid = 1'b0;
  endtask

  task automatic write_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input int early_last, input bit store,
                             input logic [1:0] exp_resp, input bit rnd_b);
    bit hs;
    int t;
    int base;
    base = int'(addr[5 +: 10]);
    do_aw(tag, id, addr, len);
    for (int b = 0; b <= int'(len); b++) begin
      bus.wdata = wbeat[b]; bus.wstrb = wstrb_arr[b];
      bus.wlast = (b == int'(len)) || (b == early_last);
      bus.wvalid = 1'b1;
      t = 0;
      forever begin
        #1;
        hs = bus.wready;
        if (b == 0 && t == 0) check({tag, " wready at N+1"}, DW'(bus.wready), DW'(1'b1));
        if (ar_pending) check({tag, " arready low in write"}, DW'(bus.arready), DW'(1'b0));
        tick();
        if (hs) break;
        if (++t > 50) begin check({tag, " w timeout"}, DW'(bus.wready), DW'(1'b1)); break; end
      end
      if (store) begin
        if (!model.exists(base + b)) model[base + b] = '0;
        for (int k = 0; k < DW/8; k++)
          if (wstrb_arr[b][k]) model[base + b][k*8 +: 8] = wbeat[b][k*8 +: 8];
      end
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    #1;
    check({tag, " bvalid at M+1"}, DW'(bus.bvalid), DW'(1'b1));
    check({tag, " wready off after last"}, DW'(bus.wready), DW'(1'b0));
    t = 0;
    forever begin
      bus.bready = rnd_b ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hs = bus.bvalid && bus.bready;
      check({tag, " bvalid held"}, DW'(bus.bvalid), DW'(1'b1));
      check({tag, " bid"}, DW'(bus.bid), DW'(id));
      check({tag, " bresp"}, DW'(bus.bresp), DW'(exp_resp));
      if (ar_pending) check({tag, " arready low in resp"}, DW'(bus.arready), DW'(1'b0));
      tick();
      if (hs) break;
      if (++t > 100) begin check({tag, " b timeout"}, DW'(bus.bvalid), DW'(1'b0)); break; end
    end
    bus.bready = 1'b0;
  endtask

  task automatic read_burst(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input bit err, input bit rnd_r, input int lat);
    bit hs;
    int t;
    int beat;
    int base;
    logic [DW-1:0] want;
    base = int'(addr[5 +: 10]);
    do_ar(tag, id, addr, len);
    t = 0;
    while (!bus.rvalid && t < 50) begin tick(); t++; end
    check({tag, " first rvalid latency"}, DW'(t), DW'(lat));
    beat = 0;
    t = 0;
    while (beat <= int'(len)) begin
      bus.rready = rnd_r ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      want = err ? '0 : model[base + beat];
      check({tag, " rvalid held"}, DW'(bus.rvalid), DW'(1'b1));
      check({tag, " rdata"}, bus.rdata, want);
      check({tag, " rresp"}, DW'(bus.rresp), DW'(err ? 2'b10 : 2'b00));
      check({tag, " rlast"}, DW'(bus.rlast), DW'(beat == int'(len)));
      check({tag, " rid"}, DW'(bus.rid), DW'(id));
      hs = bus.rvalid && bus.rready;
      if (hs) rd_got[beat] = bus.rdata;
      tick();
      if (hs) beat++;
      if (++t > 200) begin check({tag, " r timeout"}, DW'(beat), DW'(len) + 1); break; end
    end
    bus.rready = 1'b0;
    #1;
    check({tag, " no extra beat"}, DW'(bus.rvalid), DW'(1'b0));
  endtask

  initial begin
    int t;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst awready", DW'(bus.awready), DW'(1'b0));
    check("rst arready", DW'(bus.arready), DW'(1'b0));
    check("rst wready", DW'(bus.wready), DW'(1'b0));
    check("rst bvalid", DW'(bus.bvalid), DW'(1'b0));
    check("rst rvalid", DW'(bus.rvalid), DW'(1'b0));
    check("rst bresp", DW'(bus.bresp), DW'(2'b00));
    check("rst rresp", DW'(bus.rresp), DW'(2'b00));
    check("rst rdata", bus.rdata, '0);
    check("rst bid", DW'(bus.bid), DW'(4'h0));
    check("rst rid", DW'(bus.rid), DW'(4'h0));
    check("rst rlast", DW'(bus.rlast), DW'(1'b0));
    rst_n = 1'b1;
    tick();
    check("idle awready", DW'(bus.awready), DW'(1'b1));

    // Single write then read at 0x40
    wbeat[0] = {32{8'hA5}}; wstrb_arr[0] = '1;
    write_burst("single_wr", 4'h3, 40'h40, 8'd0, -1, 1'b1, 2'b00, 1'b0);
    read_burst("single_rd", 4'h5, 40'h40, 8'd0, 1'b0, 1'b0, LAT);
    check("single_rd value", rd_got[0], {32{8'hA5}});

    // Burst with a partial strobe on word 2
    for (int b = 0; b < 4; b++) begin
      wbeat[b] = {8{32'(32'h1000_0000 + b)}}; wstrb_arr[b] = '1;
    end
    write_burst("burst_fill", 4'h1, 40'h0, 8'd3, -1, 1'b1, 2'b00, 1'b0);
    for (int b = 0; b < 4; b++) begin
      wbeat[b] = {8{32'(32'h2000_0000 + b)}}; wstrb_arr[b] = '1;
    end
    wstrb_arr[2] = 32'h0000_000F;
    write_burst("burst_strb", 4'h2, 40'h0, 8'd3, -1, 1'b1, 2'b00, 1'b0);
    read_burst("burst_rd", 4'h6, 40'h0, 8'd3, 1'b0, 1'b0, LAT);
    check("burst word2 bytes0-3", rd_got[2], {{7{32'h1000_0002}}, 32'h2000_0002});
    check("burst word3 full", rd_got[3], {8{32'h2000_0003}});

    // Backpressure on B and R, len 7
    for (int b = 0; b < 8; b++) begin
      wbeat[b] = {8{32'(32'h3000_0000 + 32'h11 * b)}}; wstrb_arr[b] = '1;
    end
    write_burst("bp_wr", 4'h7, 40'h1000, 8'd7, -1, 1'b1, 2'b00, 1'b1);
    read_burst("bp_rd", 4'h8, 40'h1000, 8'd7, 1'b0, 1'b1, LAT);
    check("bp_rd beat5", rd_got[5], {8{32'h3000_0055}});

    // Simultaneous AW and AR: write first, then the read sees the new data
    wbeat[0] = {16{16'hBEEF}}; wbeat[1] = {16{16'hCAFE}};
    wstrb_arr[0] = '1; wstrb_arr[1] = '1;
    bus.arid = 4'hC; bus.araddr = 40'h2000; bus.arlen = 8'd1; bus.arvalid = 1'b1;
    ar_pending = 1'b1;
    write_burst("both_wr", 4'hB, 40'h2000, 8'd1, -1, 1'b1, 2'b00, 1'b0);
    ar_pending = 1'b0;
    read_burst("both_rd", 4'hC, 40'h2000, 8'd1, 1'b0, 1'b0, LAT);
    check("both_rd beat1", rd_got[1], {16{16'hCAFE}});

    // Read with address bit 30 set
    read_burst("err_rd_hi", 4'hD, 40'h00_4000_0040, 8'd0, 1'b1, 1'b0, LAT);

    // Write running past the last word leaves memory untouched
    wbeat[0] = {32{8'h5C}}; wstrb_arr[0] = '1;
    write_burst("top_word_wr", 4'h4, 40'h7FE0, 8'd0, -1, 1'b1, 2'b00, 1'b0);
    wbeat[0] = {32{8'hEE}}; wbeat[1] = {32{8'hEE}};
    wstrb_arr[0] = '1; wstrb_arr[1] = '1;
    write_burst("err_wr_over", 4'hE, 40'h7FE0, 8'd1, -1, 1'b0, 2'b10, 1'b0);
    read_burst("top_word_rd", 4'h4, 40'h7FE0, 8'd0, 1'b0, 1'b0, LAT);
    check("top word unchanged", rd_got[0], {32{8'h5C}});

    // Early wlast on a len 2 burst: data still stored, response SLVERR
    for (int b = 0; b < 3; b++) begin
      wbeat[b] = {8{32'(32'h4000_0000 + b)}}; wstrb_arr[b] = '1;
    end
    write_burst("err_wlast", 4'hA, 40'h3000, 8'd2, 0, 1'b1, 2'b10, 1'b0);
    read_burst("wlast_rd", 4'hA, 40'h3000, 8'd2, 1'b0, 1'b0, LAT);

    // Reset asserted while beat 2 of 4 is presented
    do_ar("rst_rd", 4'h9, 40'h0, 8'd3);
    t = 0;
    while (!bus.rvalid && t < 50) begin tick(); t++; end
    bus.rready = 1'b1;
    #1;
    check("rst_rd beat0", bus.rdata, {8{32'h2000_0000}});
    tick();
    bus.rready = 1'b0;
    #1;
    check("rst_rd beat1 presented", DW'(bus.rvalid), DW'(1'b1));
    rst_n = 1'b0;
    tick();
    check("rst_rd rvalid dropped", DW'(bus.rvalid), DW'(1'b0));
    check("rst_rd rdata cleared", bus.rdata, '0);
    check("rst_rd rlast cleared", DW'(bus.rlast), DW'(1'b0));
    tick();
    rst_n = 1'b1;
    tick();
    read_burst("rst_reread", 4'h9, 40'h0, 8'd3, 1'b0, 1'b0, LAT);
    check("rst_reread word2", rd_got[2], {{7{32'h1000_0002}}, 32'h2000_0002});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
